// File: rtl/dist_pkg.sv
// Shared latency constants and scheduler state encoding for the distance-calculation path.
package dist_pkg;

  localparam int unsigned DIST_PIPE_LAT  = 4;
  localparam int unsigned CENTER_MEM_LAT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/tag_delay_line.sv
// Fixed-depth shift register of {valid, tag} that follows operands through memory and datapath.
module tag_delay_line #(
  parameter int unsigned DEPTH = 5,
  parameter int unsigned W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_tag,
  output logic         out_valid,
  output logic [W-1:0] out_tag,
  output logic         any_valid
);

  logic [DEPTH-1:0] valid_q;
  logic [W-1:0]     tag_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= '0;
    end else begin
      valid_q[0] <= in_valid;
      for (int unsigned i = 1; i < DEPTH; i++) valid_q[i] <= valid_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    tag_q[0] <= in_tag;
    for (int unsigned i = 1; i < DEPTH; i++) tag_q[i] <= tag_q[i-1];
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_tag   = tag_q[DEPTH-1];

  // Excludes the output stage: low means nothing arrives after the current output.
  always_comb begin
    any_valid = 1'b0;
    for (int unsigned i = 0; i + 1 < DEPTH; i++) any_valid = any_valid | valid_q[i];
  end

endmodule

// File: rtl/nearest_center_scheduler.sv
// Streams every stored center through the distance datapath and keeps the nearest one.
module nearest_center_scheduler
  import dist_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_CENTERS = 16,
  parameter int unsigned IDX_W       = 4,
  parameter int unsigned MEM_LAT     = CENTER_MEM_LAT,
  parameter int unsigned PIPE_LAT    = DIST_PIPE_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic [IDX_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0] dist_in,
  output logic [IDX_W-1:0]  best_idx,
  output logic [DATA_W-1:0] best_dist
);

  localparam int unsigned      TOTAL_LAT = MEM_LAT + PIPE_LAT;
  localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(NUM_CENTERS - 1);

  sched_state_t      state_q, state_d;
  logic [IDX_W-1:0]  addr_q, addr_d;
  logic              first_q, first_d;
  logic [IDX_W-1:0]  best_idx_q;
  logic [DATA_W-1:0] best_dist_q;

  logic              running, flush, take;
  logic              out_valid, in_flight;
  logic [IDX_W-1:0]  out_tag;

  assign running = (state_q == ISSUE) || (state_q == DRAIN);
  assign flush   = running && abort;

  tag_delay_line #(
    .DEPTH (TOTAL_LAT),
    .W     (IDX_W)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (state_q == ISSUE),
    .in_tag    (addr_q),
    .out_valid (out_valid),
    .out_tag   (out_tag),
    .any_valid (in_flight)
  );

  // First result of a run loads unconditionally; strict less-than keeps the lowest index on ties.
  assign take = out_valid && !flush && (first_q || (dist_in < best_dist_q));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    first_d = first_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = ISSUE;
          addr_d  = '0;
          first_d = 1'b1;
        end
      end
      ISSUE: begin
        if (abort) begin
          state_d = IDLE;
          addr_d  = '0;
        end else if (addr_q == LAST_ADDR) begin
          state_d = DRAIN;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (abort) state_d = IDLE;
        else if (!in_flight) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (take) first_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      first_q     <= 1'b0;
      best_idx_q  <= '0;
      best_dist_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      first_q <= first_d;
      if (take) begin
        best_idx_q  <= out_tag;
        best_dist_q <= dist_in;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign mem_en    = (state_q == ISSUE);
  assign mem_addr  = addr_q;
  assign best_idx  = best_idx_q;
  assign best_dist = best_dist_q;

endmodule

// File: tb/tb_nearest_center_scheduler.sv
// Directed bench: models center RAM plus datapath as a fixed delay of a per-index distance table.
module tb_nearest_center_scheduler;

  localparam int TL = 5;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic        busy, done, mem_en;
  logic [3:0]  mem_addr, best_idx;
  logic [31:0] dist_in, best_dist;

  logic        rst1, start1;
  logic        busy1, done1, mem_en1;
  logic [0:0]  mem_addr1, best_idx1;
  logic [31:0] dist_in1, best_dist1;

  always #5 clk = ~clk;

  nearest_center_scheduler u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .dist_in   (dist_in),
    .best_idx  (best_idx),
    .best_dist (best_dist)
  );

  nearest_center_scheduler #(
    .NUM_CENTERS (1),
    .IDX_W       (1)
  ) u_dut1 (
    .clk       (clk),
    .rst       (rst1),
    .start     (start1),
    .abort     (1'b0),
    .busy      (busy1),
    .done      (done1),
    .mem_en    (mem_en1),
    .mem_addr  (mem_addr1),
    .dist_in   (dist_in1),
    .best_idx  (best_idx1),
    .best_dist (best_dist1)
  );

  // RAM + datapath model; results with no valid request read as 0 to expose ungated compares.
  logic [31:0]   tbl [16];
  logic [TL-1:0] v0 = '0;
  logic [3:0]    a0 [TL];
  logic [TL-1:0] v1 = '0;

  always @(posedge clk) begin
    v0    <= {v0[TL-2:0], mem_en};
    a0[0] <= mem_addr;
    for (int i = 1; i < TL; i++) a0[i] <= a0[i-1];
    v1    <= {v1[TL-2:0], mem_en1};
  end

  assign dist_in  = v0[TL-1] ? tbl[a0[TL-1]] : 32'd0;
  assign dist_in1 = v1[TL-1] ? 32'hFFFF_FFFF : 32'd0;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  int done_cyc, n_done, n_busy, n_issue, addr_err, stale;
  logic [31:0] snap [6];

  // Cycle 0 is the cycle start is held; inputs for cycle n are driven at its negedge.
  task automatic run_search(input int st_a, input int st_b, input int abort_at, input int rst_at,
                            input int snap_at, input int window);
    done_cyc = -1; n_done = 0; n_busy = 0; n_issue = 0; addr_err = 0; stale = 0;
    @(negedge clk);
    for (int n = 0; n <= window; n++) begin
      if (n > 0) begin
        if (done) begin
          n_done++;
          if (done_cyc < 0) done_cyc = n;
        end
        if (busy) n_busy++;
        if (mem_en) begin
          if (int'(mem_addr) != n_issue) addr_err++;
          n_issue++;
        end
        if (n == snap_at) begin
          snap[0] = 32'(busy);
          snap[1] = 32'(done);
          snap[2] = 32'(mem_en);
          snap[3] = 32'(mem_addr);
          snap[4] = 32'(best_idx);
          snap[5] = best_dist;
        end
        if (rst_at >= 0 && n > rst_at && (best_dist != 0 || best_idx != 0 || busy || done))
          stale++;
      end
      start = (n == 0) || (n == st_a) || (n == st_b);
      abort = (n == abort_at);
      rst   = (n == rst_at);
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    rst1 = 1'b1; start1 = 1'b0;
    for (int i = 0; i < 16; i++) tbl[i] = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0; rst1 = 1'b0;
    @(negedge clk);

    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_mem_en", 32'(mem_en), 0);
    check_eq("rst_mem_addr", 32'(mem_addr), 0);
    check_eq("rst_best_idx", 32'(best_idx), 0);
    check_eq("rst_best_dist", best_dist, 0);

    // 1: tie between idx1 and idx3 keeps idx1
    tbl[0] = 9; tbl[1] = 4; tbl[2] = 7; tbl[3] = 4;
    for (int i = 4; i < 15; i++) tbl[i] = 32'(16 + i);
    tbl[15] = 100;
    run_search(-1, -1, -1, -1, -1, 30);
    check_eq("t1_done_cycle", 32'(done_cyc), 22);
    check_eq("t1_done_count", 32'(n_done), 1);
    check_eq("t1_busy_cycles", 32'(n_busy), 22);
    check_eq("t1_best_idx", 32'(best_idx), 1);
    check_eq("t1_best_dist", best_dist, 4);

    // 2: minimum at the last index; addresses contiguous
    for (int i = 0; i < 16; i++) tbl[i] = 50;
    tbl[15] = 3;
    run_search(-1, -1, -1, -1, -1, 30);
    check_eq("t2_issue_count", 32'(n_issue), 16);
    check_eq("t2_addr_errors", 32'(addr_err), 0);
    check_eq("t2_best_idx", 32'(best_idx), 15);
    check_eq("t2_best_dist", best_dist, 3);

    // 3: start pulsed during ISSUE and in DONE is ignored
    for (int i = 0; i < 16; i++) tbl[i] = 60;
    tbl[8] = 2; tbl[12] = 2;
    run_search(5, 22, -1, -1, -1, 50);
    check_eq("t3_done_count", 32'(n_done), 1);
    check_eq("t3_done_cycle", 32'(done_cyc), 22);
    check_eq("t3_busy_cycles", 32'(n_busy), 22);
    check_eq("t3_best_idx", 32'(best_idx), 8);
    check_eq("t3_best_dist", best_dist, 2);

    // 4: abort at cycle 10, then a fresh run must load its own first result
    for (int i = 0; i < 16; i++) tbl[i] = 90;
    tbl[0] = 1;
    run_search(-1, -1, 10, -1, 11, 30);
    check_eq("t4_busy_after_abort", snap[0], 0);
    check_eq("t4_mem_en_after_abort", snap[2], 0);
    check_eq("t4_done_count", 32'(n_done), 0);
    for (int i = 0; i < 16; i++) tbl[i] = 60;
    tbl[7] = 40;
    run_search(-1, -1, -1, -1, -1, 30);
    check_eq("t4_fresh_done_cycle", 32'(done_cyc), 22);
    check_eq("t4_fresh_best_idx", 32'(best_idx), 7);
    check_eq("t4_fresh_best_dist", best_dist, 40);

    // 5: reset at cycle 12; stale datapath results must not land
    for (int i = 0; i < 16; i++) tbl[i] = 5;
    run_search(-1, -1, -1, 12, 13, 30);
    check_eq("t5_busy", snap[0], 0);
    check_eq("t5_done", snap[1], 0);
    check_eq("t5_mem_en", snap[2], 0);
    check_eq("t5_mem_addr", snap[3], 0);
    check_eq("t5_best_idx", snap[4], 0);
    check_eq("t5_best_dist", snap[5], 0);
    check_eq("t5_stale_cycles", 32'(stale), 0);
    check_eq("t5_done_count", 32'(n_done), 0);

    // 6: single center, all-ones distance
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 1;
    while (!done1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("t6_done_cycle", 32'(n), 7);
    check_eq("t6_best_idx", 32'(best_idx1), 0);
    check_eq("t6_best_dist", best_dist1, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
